// File: rtl/trade_order_ctrl.sv
// Order-issue controller: turns SMA buy/sell pulses into single valid/ready orders
// under a signed position limit and a post-trade cooldown, counting dropped signals.
module trade_order_ctrl #(
  parameter int MAX_POS  = 4,
  parameter int POS_W    = 4,
  parameter int COOLDOWN = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_data_valid_sma,
  input  logic             i_buy_signal,
  input  logic             i_sell_signal,
  input  logic             i_order_ready,
  output logic             o_order_valid,
  output logic             o_order_side,
  output logic [7:0]       o_order_id,
  output logic [POS_W-1:0] o_position,
  output logic             o_busy,
  output logic [7:0]       o_drop_count
);

  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam bit HAS_COOL = (COOLDOWN > 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;
  localparam logic signed [POS_W-1:0] POS_HI  = POS_W'(MAX_POS);
  localparam logic signed [POS_W-1:0] POS_LO  = -POS_HI;
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_order_valid;
  logic                     r_order_side;
  logic [7:0]               r_order_id;
  logic signed [POS_W-1:0]  r_position;
  logic [7:0]               r_drop_count;

  state_t                   w_state_next;
  logic [CNT_W-1:0]         w_cnt_next;
  logic                     w_order_valid_next;
  logic                     w_order_side_next;
  logic [7:0]               w_order_id_next;
  logic signed [POS_W-1:0]  w_position_next;
  logic [7:0]               w_drop_count_next;
  logic                     w_drop;
  logic                     w_accept;
  logic                     w_sig_any;
  logic                     w_conflict;

  assign w_accept   = r_order_valid & i_order_ready;
  assign w_sig_any  = i_data_valid_sma & (i_buy_signal | i_sell_signal);
  assign w_conflict = i_data_valid_sma & i_buy_signal & i_sell_signal;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_order_valid <= 1'b0;
      r_order_side  <= 1'b0;
      r_order_id    <= 8'd0;
      r_position    <= '0;
      r_drop_count  <= 8'd0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_order_valid <= w_order_valid_next;
      r_order_side  <= w_order_side_next;
      r_order_id    <= w_order_id_next;
      r_position    <= w_position_next;
      r_drop_count  <= w_drop_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_order_valid_next = r_order_valid;
    w_order_side_next  = r_order_side;
    w_order_id_next    = r_order_id;
    w_position_next    = r_position;
    w_drop             = 1'b0;

    case (r_state)
      S_IDLE: begin
        // With trading disabled every signal, conflicting or not, is ignored uncounted.
        if (i_enable && i_data_valid_sma) begin
          if (w_conflict) begin
            w_drop = 1'b1;
          end else if (i_buy_signal) begin
            if (r_position < POS_HI) begin
              w_order_side_next  = 1'b1;
              w_order_valid_next = 1'b1;
              w_state_next       = S_ISSUE;
            end else begin
              w_drop = 1'b1;
            end
          end else if (i_sell_signal) begin
            if (r_position > POS_LO) begin
              w_order_side_next  = 1'b0;
              w_order_valid_next = 1'b1;
              w_state_next       = S_ISSUE;
            end else begin
              w_drop = 1'b1;
            end
          end
        end
      end

      S_ISSUE: begin
        w_drop = w_sig_any;
        if (w_accept) begin
          w_order_valid_next = 1'b0;
          w_order_id_next    = r_order_id + 8'd1;
          w_position_next    = r_order_side ? (r_position + POS_ONE)
                                            : (r_position - POS_ONE);
          w_cnt_next         = CNT_LOAD;
          w_state_next       = HAS_COOL ? S_COOL : S_IDLE;
        end
      end

      S_COOL: begin
        w_drop = w_sig_any;
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_next       = S_IDLE;
        w_order_valid_next = 1'b0;
      end
    endcase

    w_drop_count_next = (w_drop && (r_drop_count != 8'hFF)) ? (r_drop_count + 8'd1)
                                                            : r_drop_count;
  end

  assign o_order_valid = r_order_valid;
  assign o_order_side  = r_order_side;
  assign o_order_id    = r_order_id;
  assign o_position    = r_position;
  assign o_busy        = (r_state != S_IDLE);
  assign o_drop_count  = r_drop_count;

endmodule

// File: doc/trade_order_ctrl.md
Name: trade_order_ctrl

Overview:
Order-issue controller that sequences the SMA strategy's buy/sell pulses into single, flow-controlled orders for the downstream order encoder. It sits directly after the SMA signal stage. It enforces a signed position limit, a post-trade cooldown and a valid/ready handshake, and counts every signal it has to drop. It is the single point where strategy decisions become committed trades.

Parameters:
MAX_POS, 4, absolute position limit in lots. Legal range 1..7.
POS_W, 4, width of the signed position register. Must satisfy 2^(POS_W-1) > MAX_POS.
COOLDOWN, 8, idle cycles enforced after each accepted order. 0 means no cooldown.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
enable  input  1  trading enable / kill switch; gates new orders only
data_valid_sma  input  1  qualifies buy_signal/sell_signal this cycle
buy_signal  input  1  strategy buy request
sell_signal  input  1  strategy sell request
order_ready  input  1  downstream accepts the order when high with order_valid
order_valid  output  1  order pending on the interface
order_side  output  1  1 = buy, 0 = sell; valid while order_valid
order_id  output  8  sequence number of the pending order
position  output  POS_W  signed net position in lots
busy  output  1  high in ISSUE or COOL
drop_count  output  8  saturating count of dropped signals

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0: order_valid, order_side, order_id, position, busy, drop_count. Cooldown counter 0. order_valid falls immediately, without waiting for a clock edge.
- Definition: a request is a cycle with data_valid_sma=1, enable=1 and exactly one of buy_signal/sell_signal high.
- IDLE:
  - Buy request with position < MAX_POS: latch order_side=1, go to ISSUE.
  - Sell request with position > -MAX_POS: latch order_side=0, go to ISSUE.
  - order_valid rises on the next clk edge (1-cycle latency, registered).
- Dropped in IDLE (drop_count +1, no state change):
  - data_valid_sma=1 with both buy and sell high (conflict).
  - A request blocked by the position limit.
- Not counted in IDLE: enable=0, or data_valid_sma=0. Signals are ignored silently.
- ISSUE:
  - order_valid=1. order_side and order_id are held stable until acceptance.
  - Accept = order_valid & order_ready at a clk edge. On accept:
    - position increments on buy, decrements on sell.
    - order_id increments, wrapping 255 -> 0.
    - order_valid falls on the same edge.
    - Next state is COOL with counter = COOLDOWN-1, or IDLE if COOLDOWN=0.
  - No withdrawal: deasserting enable in ISSUE does not drop the order.
  - Any data_valid_sma=1 cycle with buy or sell high while in ISSUE: drop_count +1.
- COOL:
  - Counter decrements each cycle. Go to IDLE on the edge where the counter is 0, giving exactly COOLDOWN cycles in COOL.
  - data_valid_sma=1 with buy or sell high: drop_count +1, signal discarded.
- busy = (state != IDLE), combinational from state.
- drop_count saturates at 255; it never wraps.
- The position never exceeds ±MAX_POS. The check uses the registered position before the order is issued.
- Simultaneous events: only one order is ever in flight. A request arriving on the acceptance edge is dropped and counted, because the state is ISSUE at that edge.
- Reset mid-ISSUE or mid-COOL: the pending order is discarded and position returns to 0. The downstream must treat rst as a flush.

Test Plan:
1. Reset release, enable=1, one buy request (dv=1, buy=1), order_ready=1 -> order_valid high 1 cycle after the request with side=1, id=0. Then position=1, id=1, busy for 1+8 cycles.
2. Sell request with order_ready=0 for 5 cycles, then 1 -> order_valid, side=0 and id held stable all 5 cycles. Position falls by 1 only on the accept edge. No extra order is issued.
3. Five buy requests spaced by the cooldown, order_ready=1, MAX_POS=4 -> four orders accepted, position=4. The fifth request is dropped: drop_count=1, no order_valid.
4. dv=1 with buy=1 and sell=1 in IDLE -> no order, drop_count +1. Then a buy request with enable=0 -> no order and drop_count unchanged.
5. Buy accepted, then buy requests on cooldown cycles 2 and 5 -> both dropped, drop_count=2. A request at cycle 9 (IDLE) issues normally. With COOLDOWN=0, back-to-back requests are accepted on alternate cycles.
6. Pull rst low mid-ISSUE with order_ready=0 -> order_valid falls before the next clk edge. All outputs read 0 after release. 300 forced conflict drops -> drop_count reads 255.
